execute: RTL

- Execute stage; sits directly downstream of `decode`.
- Consumes decode's registered outputs and selects operands, with a one-entry result bypass.
- Performs the RV32I integer ALU operation, using a multi-cycle serial shifter for shifts.
- Registers result, destination and write-enable back toward the register file; for loads, produces the memory address.
- Holds the upstream stage with `stall_out` while a shift is in progress.

---
 rtl/execute.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/execute.sv
// Execute stage: operand select with a one-entry result bypass, RV32I ALU,
// serial shifter that stalls upstream, registered writeback and load address.
//
// state | meaning
// IDLE  | accepting instructions; non-shift ops complete in one cycle
// SHIFT | serial shift in progress, one bit per cycle; upstream stalled
module execute #(
  parameter int XLEN = 32
) (
  input  logic            req,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic [6:0]      alu_op_in,
  input  logic            alu_sub_sra_in,
  input  logic [2:0]      alu_src1_in,
  input  logic [2:0]      alu_src2_in,
  input  logic [4:0]      rd_in,
  input  logic            rd_write_in,
  input  logic [XLEN-1:0] rs1_value_in,
  input  logic [XLEN-1:0] rs2_value_in,
  input  logic [XLEN-1:0] imm_value_in,
  output logic            stall_out,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic            mem_read_out,
  output logic [XLEN-1:0] mem_addr_out
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic              byp_valid;
  logic [4:0]        byp_rd;
  logic [XLEN-1:0]   byp_value;
  logic [XLEN-1:0]   sh_acc;
  logic [4:0]        sh_cnt;
  logic              sh_left;
  logic              sh_arith;
  logic [4:0]        sh_rd;
  logic              sh_wr;

  logic              is_r, is_i, is_load, is_alu, is_shift;
  logic              hit1, hit2;
  logic [XLEN-1:0]   op_a, op_b, sum, alu_res, res_next, sh_next;
  logic [4:0]        shamt;
  logic              wr_eff;

  // funct7 is already folded into alu_sub_sra_in by decode
  logic unused_funct7;
  assign unused_funct7 = ^funct7_in;

  assign stall_out = (state == SHIFT);

  assign is_r     = (alu_op_in == OP_R);
  assign is_i     = (alu_op_in == OP_I);
  assign is_load  = (alu_op_in == OP_LOAD);
  assign is_alu   = is_r | is_i;
  assign is_shift = is_alu & ((funct3_in == 3'b001) | (funct3_in == 3'b101));

  assign hit1 = byp_valid && (byp_rd != 5'd0) && (byp_rd == rs1_in);
  assign hit2 = byp_valid && (byp_rd != 5'd0) && (byp_rd == rs2_in);

  // Operand selection; bypass only applies to the register-sourced value
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (alu_src1_in == 3'b000) op_a = hit1 ? byp_value : rs1_value_in;
    case (alu_src2_in)
      3'b000:  op_b = hit2 ? byp_value : rs2_value_in;
      3'b001:  op_b = imm_value_in;
      default: op_b = '0;
    endcase
  end

  assign sum    = op_a + op_b;
  assign shamt  = op_b[4:0];
  assign wr_eff = rd_write_in & (rd_in != 5'd0) & is_alu;

  // Single-cycle ALU; shift cases only reach here with a zero shift amount
  always_comb begin
    alu_res = '0;
    case (funct3_in)
      3'b000:  alu_res = (is_r && alu_sub_sra_in) ? (op_a - op_b) : sum;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100:  alu_res = op_a ^ op_b;
      3'b110:  alu_res = op_a | op_b;
      3'b111:  alu_res = op_a & op_b;
      default: alu_res = op_a;
    endcase
  end

  // Result selection by opcode class; unknown opcodes produce zero
  always_comb begin
    res_next = '0;
    if (is_load)     res_next = sum;
    else if (is_alu) res_next = alu_res;
  end

  // One-bit step of the serial shifter
  always_comb begin
    sh_next = '0;
    if (sh_left) sh_next = {sh_acc[XLEN-2:0], 1'b0};
    else         sh_next = {sh_arith & sh_acc[XLEN-1], sh_acc[XLEN-1:1]};
  end

  // Control FSM, registered outputs and bypass entry
  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid_out    <= 1'b0;
      result_out   <= '0;
      rd_out       <= '0;
      rd_write_out <= 1'b0;
      mem_read_out <= 1'b0;
      mem_addr_out <= '0;
      byp_valid    <= 1'b0;
      byp_rd       <= '0;
      byp_value    <= '0;
      sh_acc       <= '0;
      sh_cnt       <= '0;
      sh_left      <= 1'b0;
      sh_arith     <= 1'b0;
      sh_rd        <= '0;
      sh_wr        <= 1'b0;
    end else begin
      valid_out    <= 1'b0;
      mem_read_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (is_shift && (shamt != 5'd0)) begin
              sh_acc   <= op_a;
              sh_cnt   <= shamt;
              sh_left  <= (funct3_in == 3'b001);
              sh_arith <= (funct3_in == 3'b101) & alu_sub_sra_in;
              sh_rd    <= rd_in;
              sh_wr    <= wr_eff;
              state    <= SHIFT;
            end else begin
              result_out   <= res_next;
              rd_out       <= rd_in;
              rd_write_out <= wr_eff;
              valid_out    <= 1'b1;
              mem_read_out <= is_load;
              if (is_load) mem_addr_out <= sum;
              if (wr_eff) begin
                byp_valid <= 1'b1;
                byp_rd    <= rd_in;
                byp_value <= res_next;
              end
            end
          end
        end
        SHIFT: begin
          sh_acc <= sh_next;
          sh_cnt <= sh_cnt - 5'd1;
          if (sh_cnt == 5'd1) begin
            result_out   <= sh_next;
            rd_out       <= sh_rd;
            rd_write_out <= sh_wr;
            valid_out    <= 1'b1;
            state        <= IDLE;
            if (sh_wr) begin
              byp_valid <= 1'b1;
              byp_rd    <= sh_rd;
              byp_value <= sh_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
